led_ctrl: RTL and testbench

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_ctrl_pkg.sv | 26 ++
 rtl/led_ctrl_key_debounce.sv | 105 ++++++++++
 rtl/led_ctrl.sv | 80 ++++++++
 tb/tb_led_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Purpose: shared types and defaults for the LED selection controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package led_ctrl_pkg;

  // Defaults for the top-level parameters.
  localparam int unsigned CLK_FREQ_DEF     = 50_000_000;
  localparam int unsigned DEBOUNCE_CYC_DEF = 1_000_000;

  // Highest legal led_sel index (three LEDs: 0..2).
  localparam logic [1:0] LED_LAST = 2'd2;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  // Round-robin advance over the three LED indices.
  function automatic logic [1:0] led_next(input logic [1:0] cur);
    return (cur >= LED_LAST) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/led_ctrl_key_debounce.sv
// Purpose: synchronize and debounce one active-low push button, emit a press pulse.
// Latency: press pulses DEBOUNCE_CYC+2 cycles after the first edge sampling the key low.
// Backpressure: none; the key is free-running and the pulse is fire-and-forget.
//
// Ports:
//   clk    - core clock, rising edge
//   rst    - asynchronous active-high reset
//   key_n  - raw asynchronous button, 0 = pressed
//   press  - registered one-cycle pulse on each debounced press
module key_debounce
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  // The counter only needs to reach DEBOUNCE_CYC-1: the entry edge into a
  // wait state is itself the first stable sample.
  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_q1;
  logic          sync_q2;
  deb_state_t    state;
  deb_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          press_nxt;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= press_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    case (state)
      RELEASED: begin
        if (!sync_q2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync_q2) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          // Only this transition produces an event.
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (sync_q2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!sync_q2) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/led_ctrl.sv
// Purpose: 1 s tick generator plus debounced select/reload buttons choosing an LED index.
// Latency: load_en/led_sel update one cycle after a debounced press; delay_1s every CLK_FREQ cycles.
// Backpressure: none; all outputs are single-cycle strobes or levels with no handshake.
//
// Ports:
//   clk       - core clock, rising edge
//   rst       - asynchronous active-high reset
//   key_sel   - raw active-low "select next LED" button
//   key_load  - raw active-low "reload" button
//   delay_1s  - one-cycle tick while the timer sits at CLK_FREQ-1
//   load_en   - one-cycle pulse per accepted reload press
//   led_sel   - LED index to toggle, 0..2
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_sel,
  input  logic       key_load,
  output logic       delay_1s,
  output logic       load_en,
  output logic [1:0] led_sel
);

  localparam int unsigned TW = $clog2(CLK_FREQ);
  localparam logic [TW-1:0] T_LAST = TW'(CLK_FREQ - 1);

  logic          sel_ev;
  logic          load_ev;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_sel (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_sel),
    .press (sel_ev)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_load (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_load),
    .press (load_ev)
  );

  // Any accepted press restarts the period from zero.
  always_comb begin
    timer_nxt = timer + TW'(1);
    if (sel_ev || load_ev || (timer == T_LAST)) begin
      timer_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      delay_1s <= 1'b0;
      load_en  <= 1'b0;
      led_sel  <= 2'd0;
    end else begin
      timer    <= timer_nxt;
      // Registered against the next timer value so the tick coincides with
      // timer == CLK_FREQ-1; a restart (timer_nxt = 0) can never tick since
      // CLK_FREQ >= 2.
      delay_1s <= (timer_nxt == T_LAST);
      load_en  <= load_ev;
      // Reload has priority and swallows a coincident select.
      if (load_ev) begin
        led_sel <= 2'd0;
      end else if (sel_ev) begin
        led_sel <= led_next(led_sel);
      end
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
module tb_led_ctrl;

  localparam int CF = 10;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_sel = 1'b1;
  logic       key_load = 1'b1;
  logic       delay_1s;
  logic       load_en;
  logic [1:0] led_sel;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;   // rising edges since reset release

  led_ctrl #(.CLK_FREQ(CF), .DEBOUNCE_CYC(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_sel  (key_sel),
    .key_load (key_load),
    .delay_1s (delay_1s),
    .load_en  (load_en),
    .led_sel  (led_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model. Each key is seen two edges late; a debounced level
  // flips once DB+1 consecutive samples disagree with it, and a flip to
  // "pressed" is an event that the outputs act on one edge later.
  // ---------------------------------------------------------------------
  int m_timer;
  bit m_delay, m_load;
  int m_led;
  bit m_ev [2];   // 0 = sel, 1 = load
  bit h1 [2];
  bit h2 [2];
  bit db [2];     // 1 = debounced pressed
  int run [2];

  always @(posedge clk) begin
    bit raw [2];
    bit seen;
    raw[0] = key_sel;
    raw[1] = key_load;
    if (rst) begin
      cyc = 0; m_timer = 0; m_delay = 0; m_load = 0; m_led = 0;
      for (int k = 0; k < 2; k++) begin
        m_ev[k] = 0; h1[k] = 1; h2[k] = 1; db[k] = 0; run[k] = 0;
      end
    end else begin
      cyc++;
      m_load = m_ev[1];
      if (m_ev[1])      m_led = 0;
      else if (m_ev[0]) m_led = (m_led + 1) % 3;
      if (m_ev[0] || m_ev[1]) m_timer = 0;
      else                    m_timer = (m_timer + 1) % CF;
      m_delay = (m_timer == CF - 1);
      for (int k = 0; k < 2; k++) begin
        seen  = h2[k];
        h2[k] = h1[k];
        h1[k] = raw[k];
        m_ev[k] = 0;
        if ((!seen) == db[k]) begin
          run[k] = 0;
        end else begin
          run[k]++;
          if (run[k] == DB + 1) begin
            db[k]   = !db[k];
            run[k]  = 0;
            m_ev[k] = db[k];
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("delay_1s", delay_1s, m_delay);
      check("load_en", load_en, m_load);
      check("led_sel", led_sel, m_led);
      check("led_sel_range", led_sel <= 2'd2, 1);
    end
  end

  // Hold one key low for 'hold' cycles, then let it settle released.
  task automatic press_key(input bit is_load, input int hold);
    if (is_load) key_load = 1'b0; else key_sel = 1'b0;
    repeat (hold) @(negedge clk);
    key_sel  = 1'b1;
    key_load = 1'b1;
    repeat (DB + 6) @(negedge clk);
  endtask

  initial begin
    int exp_p [3];
    int np, t0, chg, tick, nchg, nload, ld_cyc;
    logic [1:0] prev;
    exp_p[0] = 10; exp_p[1] = 20; exp_p[2] = 30;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_delay_1s", delay_1s, 0);
    check("rst_load_en", load_en, 0);
    check("rst_led_sel", led_sel, 0);
    rst = 1'b0;

    // Idle: ticks in the 10th, 20th, 30th clock period after release.
    np = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (delay_1s) begin
        if (np < 3) check("idle_tick_period", cyc + 1, exp_p[np]);
        np++;
      end
    end
    check("idle_tick_count", np, 3);

    // key_sel held 20 cycles: one press, led_sel moves 7 edges after the
    // first low sample, next tick 9 edges after that.
    key_sel = 1'b0;
    t0 = cyc + 1;
    chg = -1; tick = -1; nchg = 0; prev = led_sel;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 19) key_sel = 1'b1;
      if (led_sel != prev) begin
        nchg++;
        if (chg < 0) chg = cyc;
      end
      if (delay_1s && chg >= 0 && tick < 0) tick = cyc;
      prev = led_sel;
    end
    check("sel_latency", chg - t0, 7);
    check("sel_one_press", nchg, 1);
    check("sel_led", led_sel, 1);
    check("sel_next_tick", tick - chg, CF - 1);

    // Three-cycle glitch is ignored.
    press_key(0, 3);
    check("glitch_ignored", led_sel, 1);

    // Advance to 2, then press both on the same edge.
    press_key(0, 8);
    check("sel_to_2", led_sel, 2);
    key_sel = 1'b0; key_load = 1'b0;
    t0 = cyc + 1;
    ld_cyc = -1; nload = 0; tick = -1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 7) begin key_sel = 1'b1; key_load = 1'b1; end
      if (load_en) begin
        nload++;
        ld_cyc = cyc;
        check("both_led_zero", led_sel, 0);
        check("both_no_tick", delay_1s, 0);
      end
      if (delay_1s && ld_cyc >= 0 && tick < 0) tick = cyc;
    end
    check("both_load_latency", ld_cyc - t0, 7);
    check("both_load_count", nload, 1);
    check("both_next_tick", tick - ld_cyc, CF - 1);
    repeat (DB + 6) @(negedge clk);

    // Three presses wrap 1, 2, 0.
    press_key(0, 6); check("wrap_1", led_sel, 1);
    press_key(0, 6); check("wrap_2", led_sel, 2);
    press_key(0, 6); check("wrap_0", led_sel, 0);

    // Reset while key_load debounce counter is at 3; progress is discarded.
    key_load = 1'b0;
    t0 = cyc + 1;
    nload = 0;
    repeat (6) begin
      @(negedge clk);
      if (load_en) nload++;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_no_load", nload, 0);
    rst = 1'b0;
    t0 = cyc + 1;
    ld_cyc = -1; nload = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (load_en) begin nload++; if (ld_cyc < 0) ld_cyc = cyc; end
    end
    check("rst_load_latency", ld_cyc - t0, DB + 3);
    check("rst_load_count", nload, 1);
    key_load = 1'b1;
    repeat (DB + 6) @(negedge clk);

    // Randomized key activity with occasional resets.
    for (int i = 0; i < 250; i++) begin
      key_sel  = ($urandom_range(0, 2) != 0);
      key_load = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 40) == 0) rst = 1'b1;
      repeat ($urandom_range(1, 10)) @(negedge clk);
      rst = 1'b0;
    end
    key_sel = 1'b1; key_load = 1'b1;
    repeat (DB + 8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
